// File: rtl/pwm_out.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_out
//  Purpose  : Speaker PWM output stage. Converts a signed 8-bit audio sample
//             into a 1-bit carrier with a 256-cycle period (156.25 kHz at a
//             40 MHz clk). Samples are latched on a strobe and applied only on
//             period boundaries. A soft-start/soft-stop FSM ramps the duty
//             cycle to and from midscale to avoid speaker pops.
//  Ports    : clk          system clock
//             reset        synchronous, active-high reset
//             enable       1 = play audio, 0 = ramp down and go silent
//             sample_valid one-cycle strobe qualifying amplitude
//             amplitude    signed two's-complement sample
//             carrier      registered PWM output
//             active       high while in RUN
//             ramping      high while in RAMP_UP or RAMP_DOWN
//  Params   : RAMP_STEP    max duty change per period while ramping (1..128)
//  Options  : PWM_DITHER_EN  when defined, an 8-bit LFSR adds a 1-LSB dither
//                            to the RUN duty cycle (saturating at 255)
//  Revision : 1.0  initial release
// ============================================================================
module pwm_out #(
    parameter int RAMP_STEP = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       sample_valid,
    input  logic [7:0] amplitude,
    output logic       carrier,
    output logic       active,
    output logic       ramping
);

    typedef enum logic [1:0] {
        S_OFF       = 2'd0,
        S_RAMP_UP   = 2'd1,
        S_RUN       = 2'd2,
        S_RAMP_DOWN = 2'd3
    } state_t;

    localparam logic [7:0] c_mid  = 8'd128;
    localparam logic [8:0] c_step = 9'(RAMP_STEP);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [7:0] r_duty;
    logic [7:0] r_sample;
    logic       r_carrier;

    logic       w_boundary;
    logic [7:0] w_target;
    logic [8:0] w_up_sum;
    logic [8:0] w_dn_diff;
    logic [7:0] w_toward_mid;
    logic [7:0] w_ramp_dn;
    logic [7:0] w_run_duty;

    assign w_boundary = (r_cnt == 8'd255);
    // Offset binary: -128 -> 0, 0 -> 128, +127 -> 255.
    assign w_target   = r_sample ^ 8'h80;

    // Ramp arithmetic is done 9 bits wide so clamping can see overflow and
    // underflow before truncation.
    always_comb begin
        w_up_sum  = {1'b0, r_duty} + c_step;
        w_dn_diff = {1'b0, r_duty} - c_step;
        // Soft-start moves toward midscale from either side without overshoot.
        if (r_duty < c_mid) begin
            w_toward_mid = (w_up_sum > {1'b0, c_mid}) ? c_mid : w_up_sum[7:0];
        end else begin
            w_toward_mid = (w_dn_diff < {1'b0, c_mid}) ? c_mid : w_dn_diff[7:0];
        end
        w_ramp_dn = ({1'b0, r_duty} <= c_step) ? 8'd0 : w_dn_diff[7:0];
    end

`ifdef PWM_DITHER_EN
    logic [7:0] r_lfsr;
    logic       w_lfsr_fb;
    logic [8:0] w_dither_sum;

    // Fibonacci LFSR, taps 8,6,5,4 (bit indices 7,5,4,3).
    assign w_lfsr_fb    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_dither_sum = {1'b0, w_target} + {8'd0, r_lfsr[0]};
    assign w_run_duty   = w_dither_sum[8] ? 8'hFF : w_dither_sum[7:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= 8'hFF;
        end else if (w_boundary) begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
        end
    end
`else
    assign w_run_duty = w_target;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= 8'd0;
            r_duty    <= 8'd0;
            r_sample  <= 8'd0;
            r_state   <= S_OFF;
            r_carrier <= 1'b0;
        end else begin
            r_cnt     <= r_cnt + 8'd1;
            // Compare uses the duty of the current period; at cnt==255 the
            // old duty still applies since the update lands on the same edge.
            r_carrier <= (r_state != S_OFF) && (r_cnt < r_duty);

            // A capture in the boundary cycle is seen only at the next
            // boundary, because the FSM below reads the pre-capture sample.
            if (sample_valid) begin
                r_sample <= amplitude;
            end

            if (w_boundary) begin
                case (r_state)
                    S_OFF: begin
                        if (enable) begin
                            r_state <= S_RAMP_UP;
                        end
                    end
                    S_RAMP_UP: begin
                        if (!enable) begin
                            r_state <= S_RAMP_DOWN;
                        end else if (r_duty == c_mid) begin
                            r_state <= S_RUN;
                            r_duty  <= w_target;
                        end else begin
                            r_duty  <= w_toward_mid;
                        end
                    end
                    S_RUN: begin
                        if (!enable) begin
                            r_state <= S_RAMP_DOWN;
                        end else begin
                            r_duty  <= w_run_duty;
                        end
                    end
                    S_RAMP_DOWN: begin
                        if (enable) begin
                            r_state <= S_RAMP_UP;
                        end else if (r_duty == 8'd0) begin
                            r_state <= S_OFF;
                        end else begin
                            r_duty  <= w_ramp_dn;
                        end
                    end
                    default: begin
                        r_state <= S_OFF;
                    end
                endcase
            end
        end
    end

    assign carrier = r_carrier;
    assign active  = (r_state == S_RUN);
    assign ramping = (r_state == S_RAMP_UP) || (r_state == S_RAMP_DOWN);

endmodule
`default_nettype wire
